// File: rtl/garage_door_sequencer.sv
// Garage door motor sequencer: button edge detect, dead-time interlock, travel timeout, fault latch.
// Optional courtesy-light timer is compiled in when LIGHT_TIMER_EN is defined.
module garage_door_sequencer #(
    parameter int DEAD_TIME      = 4,
    parameter int TRAVEL_TIMEOUT = 1000,
    parameter int LIGHT_TIME     = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Wall,
    input  logic       Btn_Remote,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic       Light,
    output logic [2:0] Current
);

    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam int TW = $clog2(TRAVEL_TIMEOUT);
    localparam logic [DW-1:0] DEAD_LAST   = DW'(DEAD_TIME - 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);

    if (DEAD_TIME < 1 || TRAVEL_TIMEOUT < 2 || LIGHT_TIME < 0) begin : g_bad_params
        $error("garage_door_sequencer: illegal parameter values");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE_DN = 3'd1,
        S_MOVE_UP = 3'd2,
        S_DEAD    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          pend_up_q, pend_up_d;
    logic          last_up_q, last_up_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [TW-1:0] travel_cnt_q, travel_cnt_d;
    logic          wall_q, remote_q, hist_ok_q;
    logic          act;

    // hist_ok_q masks the first cycle after reset so a button held through reset never counts as a press
    assign act = hist_ok_q & ((Btn_Wall & ~wall_q) | (Btn_Remote & ~remote_q));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            pend_up_q    <= 1'b0;
            last_up_q    <= 1'b0;
            dead_cnt_q   <= '0;
            travel_cnt_q <= '0;
            wall_q       <= 1'b0;
            remote_q     <= 1'b0;
            hist_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_up_q    <= pend_up_d;
            last_up_q    <= last_up_d;
            dead_cnt_q   <= dead_cnt_d;
            travel_cnt_q <= travel_cnt_d;
            wall_q       <= Btn_Wall;
            remote_q     <= Btn_Remote;
            hist_ok_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_up_d    = pend_up_q;
        last_up_d    = last_up_q;
        dead_cnt_d   = dead_cnt_q;
        travel_cnt_d = travel_cnt_q;
        if (state_q != S_FAULT && UP_Max && DN_Max) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (act) begin
                        pend_up_d  = UP_Max ? 1'b0 : (DN_Max ? 1'b1 : ~last_up_q);
                        dead_cnt_d = '0;
                        state_d    = S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (Obstruct && !pend_up_q) begin
                        state_d = S_IDLE;
                    end else if (dead_cnt_q == DEAD_LAST) begin
                        state_d      = pend_up_q ? S_MOVE_UP : S_MOVE_DN;
                        last_up_d    = pend_up_q;
                        travel_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + DW'(1);
                    end
                end
                S_MOVE_UP: begin
                    if (UP_Max) begin
                        state_d = S_IDLE;
                    end else if (travel_cnt_q == TRAVEL_LAST) begin
                        state_d = S_FAULT;
                    end else if (act) begin
                        state_d = S_IDLE;
                    end else begin
                        travel_cnt_d = travel_cnt_q + TW'(1);
                    end
                end
                S_MOVE_DN: begin
                    if (DN_Max) begin
                        state_d = S_IDLE;
                    end else if (Obstruct) begin
                        state_d    = S_DEAD;
                        pend_up_d  = 1'b1;
                        dead_cnt_d = '0;
                    end else if (travel_cnt_q == TRAVEL_LAST) begin
                        state_d = S_FAULT;
                    end else if (act) begin
                        state_d = S_IDLE;
                    end else begin
                        travel_cnt_d = travel_cnt_q + TW'(1);
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;
            endcase
        end
    end

    assign Current = state_q;
    assign UP_M    = (state_q == S_MOVE_UP);
    assign DN_M    = (state_q == S_MOVE_DN);
    assign Fault   = (state_q == S_FAULT);

`ifdef LIGHT_TIMER_EN
    localparam int LW = (LIGHT_TIME > 1) ? $clog2(LIGHT_TIME) : 1;
    localparam logic [LW-1:0] LIGHT_LAST = LW'((LIGHT_TIME > 0) ? LIGHT_TIME - 1 : 0);

    logic          light_on_q, light_on_d;
    logic [LW-1:0] light_cnt_q, light_cnt_d;

    // The hold timer only matters while idle; every other state lights the lamp outright
    always_comb begin
        light_on_d  = light_on_q;
        light_cnt_d = light_cnt_q;
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            light_on_d  = (LIGHT_TIME > 0);
            light_cnt_d = '0;
        end else if (state_q == S_IDLE && light_on_q) begin
            if (light_cnt_q == LIGHT_LAST) begin
                light_on_d = 1'b0;
            end else begin
                light_cnt_d = light_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            light_on_q  <= 1'b0;
            light_cnt_q <= '0;
        end else begin
            light_on_q  <= light_on_d;
            light_cnt_q <= light_cnt_d;
        end
    end

    assign Light = (state_q != S_IDLE) | light_on_q;
`else
    assign Light = 1'b0;
`endif

endmodule
